apb3_tick_scheduler: RTL and testbench
======================================

// Module: apb3_tick_scheduler
// PURPOSE
//  APB3 slave that multiplexes one system-tick pulse into CHANNELS software timers, one-shot or periodic.
//  A single shared decrementer scans the channels sequentially after each tick.
//  Per-channel pending flags are aggregated into one interrupt line.
//  Sits beside the SysTick timer on the peripheral APB3 bus; tick_in is driven by the SysTick wrap pulse.
// PARAMETERS
//  CHANNELS  4   number of timer channels, 1..8
//  CNT_W     16  counter/reload width, 1..16
// PORTS
//  io_apb_PCLK       in   1   clock
//  io_apb_PRESET     in   1   reset, asynchronous, active-high
//  io_apb_PADDR      in   16  byte address; bits [5:2] decoded
//  io_apb_PSEL       in   1   select
//  io_apb_PENABLE    in   1   access phase
//  io_apb_PWRITE     in   1   1=write
//  io_apb_PWDATA     in   32  write data
//  io_apb_PREADY     out  1   tied 1
//  io_apb_PRDATA     out  32  read data
//  io_apb_PSLVERROR  out  1   tied 0
//  tick_in           in   1   1-cycle tick pulse, PCLK domain
//  interrupt         out  1   |(PEND & IRQ_EN)
// BEHAVIOUR
//  Register map:
//   0x00 CTRL:   [0] GEN, global enable
//   0x04 IRQ_EN: [CHANNELS-1:0]
//   0x08 PEND:   write-1-to-clear
//   0x0C STATUS: [0] BUSY (RO); [1] OVR (sticky, W1C)
//   0x10+8n CFG(n): [CNT_W-1:0] RELOAD; [16] EN; [17] PERIODIC
//   0x14+8n CNT(n): current count (RO)
//  Access: write takes effect when PSEL&PENABLE&PWRITE. PRDATA is combinational, 0 unless PSEL&PENABLE&~PWRITE.
//   Unmapped reads return 0; unmapped writes are ignored; unused bits read 0.
//  Reset: all registers, CNT and PEND = 0; FSM = IDLE; interrupt = 0; PRDATA = 0.
//  Write to CFG(n): CNT(n) <= RELOAD. Loads regardless of EN.
//  FSM: IDLE / SCAN, with index idx.
//   - IDLE -> SCAN on tick_in&GEN; idx <= 0.
//   - SCAN handles channel idx in one cycle, then idx++. After idx==CHANNELS-1 it returns to IDLE.
//   - A scan therefore lasts CHANNELS cycles. BUSY=1 in SCAN.
//  Per-channel step (EN=1 and RELOAD!=0 only; other channels untouched):
//   - CNT>1: CNT-1.
//   - CNT<=1 (expiry): PEND[n] <= 1.
//     - PERIODIC=1: CNT <= RELOAD.
//     - PERIODIC=0: CNT <= 0 and EN <= 0.
//   - Result: first expiry occurs on the RELOAD-th tick after the CFG write.
//  Boundary rules:
//   - tick_in while SCAN: tick is dropped and OVR <= 1.
//   - GEN cleared during SCAN: return to IDLE next cycle. Unscanned channels keep their count.
//   - CFG(n) write in the same cycle SCAN steps channel n: the write wins; CNT <= new RELOAD, no decrement.
//   - PEND W1C in the same cycle as expiry of the same bit: set wins. The same rule applies to OVR.
//   - CNT wraps never; decrement stops at 1.
//   - interrupt is combinational from flops only, so it is glitch-free.
//   - Reset mid-scan: FSM aborts; everything returns to reset values.
// CONFIGURATION
//  Macro TICK_SCHED_PRESCALE_EN:
//  - Defined: CTRL[15:8] = PRESC, reset 0, with an internal 8-bit prescale counter.
//    - A scan launches on every (PRESC+1)-th accepted tick. The counter resets on any CTRL write.
//    - Ticks dropped by OVR do not count.
//  - Undefined: CTRL[15:8] reads 0 and writes are ignored; every tick launches a scan.
// STRUCTURE
//  Package apb3_tick_sched_pkg:
//   - register offsets (CTRL/IRQ_EN/PEND/STATUS/CFG base/stride)
//   - CTRL, STATUS and CFG bit positions
//   - FSM state encoding: IDLE=0, SCAN=1
//  No per-channel sub-module: there is one shared decrementer, and CFG/CNT are arrays.
//  Sub-module tick_prescaler, instantiated only under TICK_SCHED_PRESCALE_EN.
// TESTING
//  1. Reset, then read all offsets -> all 0; interrupt=0; PREADY=1; PSLVERROR=0.
//  2. CFG0 = RELOAD 3, EN, PERIODIC; IRQ_EN=1; GEN=1; 3 ticks spaced 8 cycles
//     -> PEND[0]=1 and interrupt=1 one cycle after the 3rd tick, CNT0=3.
//     Then write PEND=1 -> interrupt=0.
//  3. CFG1 = RELOAD 2, EN, one-shot; 4 ticks
//     -> PEND[1] set after the 2nd tick; CFG1.EN reads 0; CNT1=0; no re-set on ticks 3-4.
//  4. CHANNELS=4, CFG0 = RELOAD 5 EN; ticks 2 cycles apart
//     -> STATUS.OVR=1, CNT0=4. Write STATUS=2 -> OVR=0.
//  5. Write CFG2 = RELOAD 9 EN in the cycle the scan handles ch2 -> CNT2=9 after the scan.
//  6. With TICK_SCHED_PRESCALE_EN: PRESC=1, CFG0 = RELOAD 2 EN -> PEND[0] set only after the 4th tick.

Source files
------------

// File: rtl/apb3_tick_sched_pkg.sv
// Shared definitions for the APB3 tick scheduler: register offsets, bit
// positions, FSM encoding and small address-decode helpers.
package apb3_tick_sched_pkg;

    localparam logic [15:0] OFF_CTRL      = 16'h0000;
    localparam logic [15:0] OFF_IRQ_EN    = 16'h0004;
    localparam logic [15:0] OFF_PEND      = 16'h0008;
    localparam logic [15:0] OFF_STATUS    = 16'h000C;
    localparam logic [15:0] OFF_CFG_BASE  = 16'h0010;
    localparam logic [15:0] OFF_CNT_DELTA = 16'h0004;
    localparam int          CH_STRIDE     = 8;

    // Only PADDR[5:2] is decoded, so channel windows past word 15 alias the
    // global registers and are treated as unmapped.
    localparam int MAX_MAPPED_CH = 6;

    localparam int CTRL_GEN_BIT     = 0;
    localparam int CTRL_PRESC_LSB   = 8;
    localparam int CTRL_PRESC_W     = 8;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_OVR_BIT   = 1;
    localparam int CFG_EN_BIT       = 16;
    localparam int CFG_PERIODIC_BIT = 17;

    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } sched_state_t;

    function automatic logic [3:0] word_of(input logic [15:0] off);
        return off[5:2];
    endfunction

    function automatic logic [3:0] cfg_word(input int n);
        logic [15:0] off;
        off = OFF_CFG_BASE + 16'(n * CH_STRIDE);
        return off[5:2];
    endfunction

    function automatic logic [3:0] cnt_word(input int n);
        logic [15:0] off;
        off = OFF_CFG_BASE + 16'(n * CH_STRIDE) + OFF_CNT_DELTA;
        return off[5:2];
    endfunction

endpackage

// File: rtl/apb3_tick_scheduler_tick_prescaler.sv
// Tick prescaler: lets every (presc+1)-th accepted tick launch a scan.
// Only instantiated when TICK_SCHED_PRESCALE_EN is defined.
module tick_prescaler
    import apb3_tick_sched_pkg::*;
(
    input  logic                    io_apb_PCLK,
    input  logic                    io_apb_PRESET,
    input  logic                    tick_ok,
    input  logic [CTRL_PRESC_W-1:0] presc,
    input  logic                    clear,
    output logic                    fire
);

    logic [CTRL_PRESC_W-1:0] count;

    // An accepted tick fires once the counter has caught up with the divider.
    always_comb begin
        fire = tick_ok && (count == presc);
    end

    // Count accepted ticks, wrapping on fire; a CTRL write restarts the count.
    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick_ok) begin
            count <= fire ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/apb3_tick_scheduler.sv
// APB3 tick scheduler: multiplexes one tick pulse into CHANNELS software
// timers using a single shared decrementer that scans channels in turn.
// Optional feature macro: TICK_SCHED_PRESCALE_EN (CTRL[15:8] tick divider).
module apb3_tick_scheduler
    import apb3_tick_sched_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic        io_apb_PCLK,
    input  logic        io_apb_PRESET,
    input  logic [15:0] io_apb_PADDR,
    input  logic        io_apb_PSEL,
    input  logic        io_apb_PENABLE,
    input  logic        io_apb_PWRITE,
    input  logic [31:0] io_apb_PWDATA,
    output logic        io_apb_PREADY,
    output logic [31:0] io_apb_PRDATA,
    output logic        io_apb_PSLVERROR,
    input  logic        tick_in,
    output logic        interrupt
);

    logic                gen;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] pend;
    logic                ovr;
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] periodic;
    logic [CNT_W-1:0]    reload [CHANNELS];
    logic [CNT_W-1:0]    cnt    [CHANNELS];

    sched_state_t     state, state_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic                wr_en, rd_en;
    logic [3:0]          word;
    logic                ctrl_wr, irq_wr, pend_wr, status_wr;
    logic [CHANNELS-1:0] cfg_wr;
    logic [CHANNELS-1:0] step_sel;
    logic [CHANNELS-1:0] expire;
    logic                step_now;
    logic                tick_ok;
    logic                launch;
    logic                ovr_set;
    logic                unused_bits;

    assign io_apb_PREADY    = 1'b1;
    assign io_apb_PSLVERROR = 1'b0;
    assign unused_bits      = ^{io_apb_PADDR[15:6], io_apb_PADDR[1:0], io_apb_PWDATA};

`ifdef TICK_SCHED_PRESCALE_EN
    logic [CTRL_PRESC_W-1:0] presc;
    logic                    presc_fire;

    tick_prescaler u_prescaler (
        .io_apb_PCLK   (io_apb_PCLK),
        .io_apb_PRESET (io_apb_PRESET),
        .tick_ok       (tick_ok),
        .presc         (presc),
        .clear         (ctrl_wr),
        .fire          (presc_fire)
    );

    // Keep the divider setting in CTRL[15:8].
    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            presc <= '0;
        end else if (ctrl_wr) begin
            presc <= io_apb_PWDATA[CTRL_PRESC_LSB +: CTRL_PRESC_W];
        end
    end
`endif

    // Decode the APB access into per-register write strobes and scan controls.
    always_comb begin
        wr_en     = io_apb_PSEL && io_apb_PENABLE && io_apb_PWRITE;
        rd_en     = io_apb_PSEL && io_apb_PENABLE && !io_apb_PWRITE;
        word      = io_apb_PADDR[5:2];
        ctrl_wr   = wr_en && (word == word_of(OFF_CTRL));
        irq_wr    = wr_en && (word == word_of(OFF_IRQ_EN));
        pend_wr   = wr_en && (word == word_of(OFF_PEND));
        status_wr = wr_en && (word == word_of(OFF_STATUS));
        tick_ok   = tick_in && gen && (state == ST_IDLE);
`ifdef TICK_SCHED_PRESCALE_EN
        launch    = presc_fire;
`else
        launch    = tick_ok;
`endif
        ovr_set   = tick_in && (state == ST_SCAN);
        step_now  = (state == ST_SCAN) && gen;
        cfg_wr    = '0;
        step_sel  = '0;
        expire    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            cfg_wr[n]   = wr_en && (n < MAX_MAPPED_CH) && (word == cfg_word(n));
            step_sel[n] = step_now && (idx == IDX_W'(n)) && en[n]
                          && (reload[n] != '0) && !cfg_wr[n];
            expire[n]   = step_sel[n] && (cnt[n] <= CNT_W'(1));
        end
    end

    // Global control, interrupt enables and sticky status flags.
    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            gen    <= 1'b0;
            irq_en <= '0;
            pend   <= '0;
            ovr    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                gen <= io_apb_PWDATA[CTRL_GEN_BIT];
            end
            if (irq_wr) begin
                irq_en <= io_apb_PWDATA[CHANNELS-1:0];
            end
            pend <= (pend & ~(pend_wr ? io_apb_PWDATA[CHANNELS-1:0] : '0)) | expire;
            ovr  <= (ovr & ~(status_wr && io_apb_PWDATA[STATUS_OVR_BIT])) | ovr_set;
        end
    end

    // Channel configuration and counters; a CFG write overrides a same-cycle step.
    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            en       <= '0;
            periodic <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                reload[n] <= '0;
                cnt[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (cfg_wr[n]) begin
                    reload[n]   <= io_apb_PWDATA[CNT_W-1:0];
                    cnt[n]      <= io_apb_PWDATA[CNT_W-1:0];
                    en[n]       <= io_apb_PWDATA[CFG_EN_BIT];
                    periodic[n] <= io_apb_PWDATA[CFG_PERIODIC_BIT];
                end else if (step_sel[n]) begin
                    if (cnt[n] > CNT_W'(1)) begin
                        cnt[n] <= cnt[n] - CNT_W'(1);
                    end else if (periodic[n]) begin
                        cnt[n] <= reload[n];
                    end else begin
                        cnt[n] <= '0;
                        en[n]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Scan FSM state and channel index registers.
    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic: one channel per SCAN cycle, abort when GEN drops.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_SCAN;
                    idx_next   = '0;
                end
            end
            ST_SCAN: begin
                if (!gen || (idx == IDX_W'(CHANNELS - 1))) begin
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Combinational read mux; zero outside a read access phase.
    always_comb begin
        io_apb_PRDATA = '0;
        if (rd_en) begin
            if (word == word_of(OFF_CTRL)) begin
                io_apb_PRDATA[CTRL_GEN_BIT] = gen;
`ifdef TICK_SCHED_PRESCALE_EN
                io_apb_PRDATA[CTRL_PRESC_LSB +: CTRL_PRESC_W] = presc;
`endif
            end else if (word == word_of(OFF_IRQ_EN)) begin
                io_apb_PRDATA[CHANNELS-1:0] = irq_en;
            end else if (word == word_of(OFF_PEND)) begin
                io_apb_PRDATA[CHANNELS-1:0] = pend;
            end else if (word == word_of(OFF_STATUS)) begin
                io_apb_PRDATA[STATUS_BUSY_BIT] = (state == ST_SCAN);
                io_apb_PRDATA[STATUS_OVR_BIT]  = ovr;
            end else begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (n < MAX_MAPPED_CH) begin
                        if (word == cfg_word(n)) begin
                            io_apb_PRDATA                   = 32'(reload[n]);
                            io_apb_PRDATA[CFG_EN_BIT]       = en[n];
                            io_apb_PRDATA[CFG_PERIODIC_BIT] = periodic[n];
                        end else if (word == cnt_word(n)) begin
                            io_apb_PRDATA = 32'(cnt[n]);
                        end
                    end
                end
            end
        end
    end

    // Interrupt is a pure function of flops, so it cannot glitch.
    always_comb begin
        interrupt = |(pend & irq_en);
    end

endmodule

// File: tb/tb_apb3_tick_scheduler.sv
// Directed self-checking bench for apb3_tick_scheduler (CHANNELS=4, CNT_W=16).
// Prescaler checks run only when TICK_SCHED_PRESCALE_EN is defined.
module tb_apb3_tick_scheduler;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [15:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverror;
    logic        tick_in = 1'b0;
    logic        interrupt;

    int total = 0;
    int bad = 0;
    logic [31:0] rd;

    apb3_tick_scheduler #(.CHANNELS(4), .CNT_W(16)) dut (
        .io_apb_PCLK      (pclk),
        .io_apb_PRESET    (preset),
        .io_apb_PADDR     (paddr),
        .io_apb_PSEL      (psel),
        .io_apb_PENABLE   (penable),
        .io_apb_PWRITE    (pwrite),
        .io_apb_PWDATA    (pwdata),
        .io_apb_PREADY    (pready),
        .io_apb_PRDATA    (prdata),
        .io_apb_PSLVERROR (pslverror),
        .tick_in          (tick_in),
        .interrupt        (interrupt)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic apbWrite(input logic [15:0] addr, input logic [31:0] data);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbRead(input logic [15:0] addr, output logic [31:0] data);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 data = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Samples PRDATA within the current cycle without crossing a clock edge.
    task automatic readNow(input logic [15:0] addr, output logic [31:0] data);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b1; paddr = addr;
        #1 data = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Raises tick_in for one edge; returns 1 time unit after that edge.
    task automatic applyStimulus();
        @(posedge pclk); #1 tick_in = 1'b1;
        @(posedge pclk); #1 tick_in = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        $display("[TB] starting");
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset state: every offset reads zero, fixed handshake outputs.
        checkOutput("rst_irq", {31'b0, interrupt}, 32'h0);
        checkOutput("rst_pready", {31'b0, pready}, 32'h1);
        checkOutput("rst_pslverr", {31'b0, pslverror}, 32'h0);
        checkOutput("rst_prdata_idle", prdata, 32'h0);
        for (int w = 0; w < 16; w++) begin
            apbRead(16'(w * 4), rd);
            checkOutput($sformatf("rst_rd_%0d", w), rd, 32'h0);
        end
        apbWrite(16'h0030, 32'h0003_0007);
        apbRead(16'h0030, rd);
        checkOutput("unmapped_wr", rd, 32'h0);

        // Periodic channel 0, reload 3.
        apbWrite(16'h0010, 32'h0003_0003);
        apbWrite(16'h0004, 32'h1);
        apbWrite(16'h0000, 32'h1);
        apbRead(16'h0014, rd);
        checkOutput("t2_cnt_load", rd, 32'd3);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0014, rd);
        checkOutput("t2_cnt_tick1", rd, 32'd2);
        applyStimulus(); idleCycles(8);
        applyStimulus();
        checkOutput("t2_irq_before_step", {31'b0, interrupt}, 32'h0);
        idleCycles(1);
        checkOutput("t2_irq_after_step", {31'b0, interrupt}, 32'h1);
        idleCycles(6);
        apbRead(16'h0008, rd);
        checkOutput("t2_pend", rd, 32'h1);
        apbRead(16'h0014, rd);
        checkOutput("t2_cnt_reloaded", rd, 32'd3);
        apbWrite(16'h0008, 32'h1);
        checkOutput("t2_irq_cleared", {31'b0, interrupt}, 32'h0);

        // One-shot channel 1, reload 2; channel 0 parked.
        apbWrite(16'h0010, 32'h0);
        apbWrite(16'h0018, 32'h0001_0002);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0008, rd);
        checkOutput("t3_pend_tick1", rd, 32'h0);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0008, rd);
        checkOutput("t3_pend_tick2", rd, 32'h2);
        checkOutput("t3_irq_masked", {31'b0, interrupt}, 32'h0);
        apbRead(16'h0018, rd);
        checkOutput("t3_cfg_en_off", rd, 32'h0000_0002);
        apbRead(16'h001C, rd);
        checkOutput("t3_cnt_zero", rd, 32'h0);
        apbWrite(16'h0008, 32'h2);
        applyStimulus(); idleCycles(8);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0008, rd);
        checkOutput("t3_no_reset", rd, 32'h0);
        apbRead(16'h001C, rd);
        checkOutput("t3_cnt_stays", rd, 32'h0);

        // Tick during a scan is dropped and flags OVR.
        apbWrite(16'h0010, 32'h0001_0005);
        @(posedge pclk); #1 tick_in = 1'b1;
        @(posedge pclk); #1 tick_in = 1'b0;
        readNow(16'h000C, rd);
        checkOutput("t4_busy", rd, 32'h1);
        @(posedge pclk); #1 tick_in = 1'b1;
        @(posedge pclk); #1 tick_in = 1'b0;
        idleCycles(8);
        apbRead(16'h000C, rd);
        checkOutput("t4_ovr", rd, 32'h2);
        apbRead(16'h0014, rd);
        checkOutput("t4_cnt", rd, 32'd4);
        apbWrite(16'h000C, 32'h2);
        apbRead(16'h000C, rd);
        checkOutput("t4_ovr_clr", rd, 32'h0);

        // CFG2 write lands in the same cycle the scan steps channel 2.
        apbWrite(16'h0020, 32'h0001_0004);
        applyStimulus();
        apbWrite(16'h0020, 32'h0001_0009);
        idleCycles(8);
        apbRead(16'h0024, rd);
        checkOutput("t5_cnt_write_wins", rd, 32'd9);
        apbRead(16'h0020, rd);
        checkOutput("t5_cfg", rd, 32'h0001_0009);
        apbRead(16'h0014, rd);
        checkOutput("t5_ch0_cnt", rd, 32'd3);

`ifdef TICK_SCHED_PRESCALE_EN
        // Divide-by-two prescaler: expiry after the 4th tick.
        apbWrite(16'h0020, 32'h0);
        apbWrite(16'h0010, 32'h0001_0002);
        apbWrite(16'h0008, 32'hF);
        apbWrite(16'h0000, 32'h0000_0101);
        apbRead(16'h0000, rd);
        checkOutput("t6_ctrl", rd, 32'h0000_0101);
        applyStimulus(); idleCycles(8);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0014, rd);
        checkOutput("t6_cnt_tick2", rd, 32'd1);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0008, rd);
        checkOutput("t6_pend_tick3", rd, 32'h0);
        applyStimulus(); idleCycles(8);
        apbRead(16'h0008, rd);
        checkOutput("t6_pend_tick4", rd, 32'h1);
`else
        // Without the prescaler CTRL[15:8] is not writable.
        apbWrite(16'h0000, 32'h0000_FF01);
        apbRead(16'h0000, rd);
        checkOutput("t6_ctrl_presc_ro", rd, 32'h1);
`endif

        // Reset in the middle of a scan returns everything to zero.
        apbWrite(16'h0010, 32'h0003_0003);
        applyStimulus();
        preset = 1'b1;
        #2;
        checkOutput("t7_irq_in_rst", {31'b0, interrupt}, 32'h0);
        idleCycles(2);
        preset = 1'b0;
        apbRead(16'h000C, rd);
        checkOutput("t7_status", rd, 32'h0);
        apbRead(16'h0014, rd);
        checkOutput("t7_cnt0", rd, 32'h0);
        apbRead(16'h0010, rd);
        checkOutput("t7_cfg0", rd, 32'h0);
        apbRead(16'h0000, rd);
        checkOutput("t7_ctrl", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
